// File: rtl/sprite_animator.sv
// Sprite motion/animation sequencer: on every tick it walks all sprites, moves and
// bounces each one, advances its animation frame and streams the update over valid/ready.
module sprite_animator #(
  parameter int NUM_SPRITES = 4,
  parameter int TICK_PERIOD = 25000000,
  parameter int X_W         = 10,
  parameter int Y_W         = 9,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int SPRITE_W    = 32,
  parameter int SPRITE_H    = 32,
  parameter int DV_W        = 4,
  parameter int SEL_W       = 5,
  parameter int ANIM_FRAMES = 2,
  localparam int IDX_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   cfg_we,
  input  logic [IDX_W-1:0]       cfg_idx,
  input  logic [X_W-1:0]         cfg_x,
  input  logic [Y_W-1:0]         cfg_y,
  input  logic signed [DV_W-1:0] cfg_dx,
  input  logic signed [DV_W-1:0] cfg_dy,
  input  logic [SEL_W-1:0]       cfg_sel,
  input  logic                   cfg_vis,
  output logic                   busy,
  output logic                   upd_valid,
  input  logic                   upd_ready,
  output logic [IDX_W-1:0]       upd_idx,
  output logic [X_W-1:0]         upd_x,
  output logic [Y_W-1:0]         upd_y,
  output logic [SEL_W-1:0]       upd_sel,
  output logic                   upd_visible,
  output logic                   pass_done,
  output logic                   tick_overrun
);

  localparam int CNT_W   = $clog2(TICK_PERIOD);
  localparam int FRAME_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam logic signed [X_W:0]   X_LIM_S  = (X_W+1)'(SCREEN_W - SPRITE_W);
  localparam logic signed [Y_W:0]   Y_LIM_S  = (Y_W+1)'(SCREEN_H - SPRITE_H);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_SPRITES - 1);
  localparam logic [FRAME_W-1:0]    LAST_FRM = FRAME_W'(ANIM_FRAMES - 1);
  localparam logic signed [DV_W-1:0] DV_MIN  = {1'b1, {(DV_W-1){1'b0}}};
  localparam logic signed [DV_W-1:0] DV_MINP = {1'b1, {(DV_W-2){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, CALC, PRESENT} state_t;

  state_t state_reg, state_next;
  logic [CNT_W-1:0] tick_cnt_reg;
  logic tick, accept, last, cfg_ok;
  logic [IDX_W-1:0] idx_reg;

  logic [X_W-1:0]         x_mem     [NUM_SPRITES];
  logic [Y_W-1:0]         y_mem     [NUM_SPRITES];
  logic signed [DV_W-1:0] dx_mem    [NUM_SPRITES];
  logic signed [DV_W-1:0] dy_mem    [NUM_SPRITES];
  logic [SEL_W-1:0]       sel_mem   [NUM_SPRITES];
  logic [FRAME_W-1:0]     frame_mem [NUM_SPRITES];
  logic                   vis_mem   [NUM_SPRITES];

  logic [X_W-1:0]         nx_reg;
  logic [Y_W-1:0]         ny_reg;
  logic signed [DV_W-1:0] ndx_reg, ndy_reg;
  logic [FRAME_W-1:0]     nframe_reg;
  logic [SEL_W-1:0]       upd_sel_reg;
  logic                   upd_vis_reg;
  logic                   pass_done_reg, tick_overrun_reg;

  logic signed [X_W:0]    nx_sum;
  logic signed [Y_W:0]    ny_sum;
  logic [X_W-1:0]         x_new;
  logic [Y_W-1:0]         y_new;
  logic signed [DV_W-1:0] dx_new, dy_new, cfg_dx_sat, cfg_dy_sat;
  logic [FRAME_W-1:0]     frame_new;
  logic [SEL_W-1:0]       sel_new;

  assign tick   = enable && (tick_cnt_reg == CNT_W'(TICK_PERIOD - 1));
  assign accept = (state_reg == PRESENT) && upd_ready;
  assign last   = (idx_reg == LAST_IDX);
  assign cfg_ok = cfg_we && (state_reg == IDLE) &&
                  ({1'b0, cfg_idx} < (IDX_W+1)'(NUM_SPRITES));

  // The most negative velocity has no positive counterpart, so clamp it to keep -dx exact.
  assign cfg_dx_sat = (cfg_dx == DV_MIN) ? DV_MINP : cfg_dx;
  assign cfg_dy_sat = (cfg_dy == DV_MIN) ? DV_MINP : cfg_dy;

  always_ff @(posedge clk) begin
    if (rst)
      tick_cnt_reg <= '0;
    else if (enable)
      tick_cnt_reg <= tick ? '0 : tick_cnt_reg + 1'b1;
  end

  always_comb begin
    nx_sum = $signed({1'b0, x_mem[idx_reg]}) +
             $signed({{(X_W+1-DV_W){dx_mem[idx_reg][DV_W-1]}}, dx_mem[idx_reg]});
    ny_sum = $signed({1'b0, y_mem[idx_reg]}) +
             $signed({{(Y_W+1-DV_W){dy_mem[idx_reg][DV_W-1]}}, dy_mem[idx_reg]});
    x_new  = nx_sum[X_W-1:0];
    dx_new = dx_mem[idx_reg];
    y_new  = ny_sum[Y_W-1:0];
    dy_new = dy_mem[idx_reg];
    if (nx_sum[X_W]) begin
      x_new  = '0;
      dx_new = -dx_mem[idx_reg];
    end else if (nx_sum > X_LIM_S) begin
      x_new  = X_LIM_S[X_W-1:0];
      dx_new = -dx_mem[idx_reg];
    end
    if (ny_sum[Y_W]) begin
      y_new  = '0;
      dy_new = -dy_mem[idx_reg];
    end else if (ny_sum > Y_LIM_S) begin
      y_new  = Y_LIM_S[Y_W-1:0];
      dy_new = -dy_mem[idx_reg];
    end
    frame_new = (frame_mem[idx_reg] == LAST_FRM) ? '0 : frame_mem[idx_reg] + 1'b1;
    sel_new   = sel_mem[idx_reg] + SEL_W'(frame_new);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (tick) state_next = CALC;
      CALC:    state_next = PRESENT;
      PRESENT: if (upd_ready) state_next = last ? IDLE : CALC;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      idx_reg          <= '0;
      nx_reg           <= '0;
      ny_reg           <= '0;
      ndx_reg          <= '0;
      ndy_reg          <= '0;
      nframe_reg       <= '0;
      upd_sel_reg      <= '0;
      upd_vis_reg      <= 1'b0;
      pass_done_reg    <= 1'b0;
      tick_overrun_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pass_done_reg <= accept && last;
      if (tick && (state_reg != IDLE))
        tick_overrun_reg <= 1'b1;
      if (state_reg == CALC) begin
        nx_reg      <= x_new;
        ny_reg      <= y_new;
        ndx_reg     <= dx_new;
        ndy_reg     <= dy_new;
        nframe_reg  <= frame_new;
        upd_sel_reg <= sel_new;
        upd_vis_reg <= vis_mem[idx_reg];
      end
      if (accept)
        idx_reg <= last ? '0 : idx_reg + 1'b1;
    end
  end

  // Config writes only happen in IDLE, so they never collide with a write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        x_mem[i]     <= '0;
        y_mem[i]     <= '0;
        dx_mem[i]    <= '0;
        dy_mem[i]    <= '0;
        sel_mem[i]   <= '0;
        frame_mem[i] <= '0;
        vis_mem[i]   <= 1'b0;
      end
    end else if (cfg_ok) begin
      x_mem[cfg_idx]     <= cfg_x;
      y_mem[cfg_idx]     <= cfg_y;
      dx_mem[cfg_idx]    <= cfg_dx_sat;
      dy_mem[cfg_idx]    <= cfg_dy_sat;
      sel_mem[cfg_idx]   <= cfg_sel;
      frame_mem[cfg_idx] <= '0;
      vis_mem[cfg_idx]   <= cfg_vis;
    end else if (accept) begin
      x_mem[idx_reg]     <= nx_reg;
      y_mem[idx_reg]     <= ny_reg;
      dx_mem[idx_reg]    <= ndx_reg;
      dy_mem[idx_reg]    <= ndy_reg;
      frame_mem[idx_reg] <= nframe_reg;
    end
  end

  assign busy         = (state_reg != IDLE);
  assign upd_valid    = (state_reg == PRESENT);
  assign upd_idx      = idx_reg;
  assign upd_x        = nx_reg;
  assign upd_y        = ny_reg;
  assign upd_sel      = upd_sel_reg;
  assign upd_visible  = upd_vis_reg;
  assign pass_done    = pass_done_reg;
  assign tick_overrun = tick_overrun_reg;

endmodule

// File: tb/tb_sprite_animator.sv
// Directed bench for sprite_animator: table of sprite setups with two passes of
// expected records, plus hand sequences for backpressure, overrun and mid-pass reset.
module tb_sprite_animator;

  localparam int NS = 4;
  localparam int TP = 20;

  logic       clk = 1'b0;
  logic       rst, enable, cfg_we, cfg_vis, upd_ready;
  logic [1:0] cfg_idx;
  logic [9:0] cfg_x;
  logic [8:0] cfg_y;
  logic [3:0] cfg_dx, cfg_dy;
  logic [4:0] cfg_sel;
  logic       busy, upd_valid, upd_visible, pass_done, tick_overrun;
  logic [1:0] upd_idx;
  logic [9:0] upd_x;
  logic [8:0] upd_y;
  logic [4:0] upd_sel;

  sprite_animator #(.NUM_SPRITES(NS), .TICK_PERIOD(TP)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_dx(cfg_dx), .cfg_dy(cfg_dy),
    .cfg_sel(cfg_sel), .cfg_vis(cfg_vis), .busy(busy), .upd_valid(upd_valid),
    .upd_ready(upd_ready), .upd_idx(upd_idx), .upd_x(upd_x), .upd_y(upd_y),
    .upd_sel(upd_sel), .upd_visible(upd_visible), .pass_done(pass_done),
    .tick_overrun(tick_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx, x, y, dx, dy, sel, vis;
    int ex1, ey1, es1, ex2, ey2, es2;
  } vec_t;

  vec_t tbl [NS];
  int n_cmp = 0;
  int n_bad = 0;
  int got_idx [NS];
  int got_x [NS];
  int got_y [NS];
  int got_sel [NS];
  int got_vis [NS];
  int first_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cfg_write(input int idx, input int x, input int y, input int dx,
                           input int dy, input int sel, input int vis);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_x = 10'(x); cfg_y = 9'(y);
    cfg_dx = 4'(dx); cfg_dy = 4'(dy); cfg_sel = 5'(sel); cfg_vis = vis[0];
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, upd_valid, 0);
    check({tag, "_idx"}, upd_idx, 0);
    check({tag, "_xysel"}, {upd_x, upd_y, upd_sel, upd_visible}, 0);
    check({tag, "_done_ovr"}, {pass_done, tick_overrun}, 0);
  endtask

  // Accept one full pass; optionally hold ready low on stall_idx for stall_n cycles.
  task automatic run_pass(input int stall_idx, input int stall_n, input string tag);
    int n_acc = 0;
    int held = 0;
    logic [24:0] snap = '0;
    first_cyc = -1;
    upd_ready = 1'b0;
    for (int cyc = 0; cyc < 200 && n_acc < NS; cyc++) begin
      @(negedge clk);
      upd_ready = 1'b0;
      if (upd_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (int'(upd_idx) == stall_idx && held < stall_n) begin
          if (held == 0) snap = {upd_x, upd_y, upd_sel, upd_visible};
          else check($sformatf("%s_hold%0d", tag, held),
                     {upd_valid, upd_x, upd_y, upd_sel, upd_visible}, {1'b1, snap});
          held++;
        end else begin
          got_idx[n_acc] = int'(upd_idx);
          got_x[n_acc]   = int'(upd_x);
          got_y[n_acc]   = int'(upd_y);
          got_sel[n_acc] = int'(upd_sel);
          got_vis[n_acc] = int'(upd_visible);
          n_acc++;
          upd_ready = 1'b1;
        end
      end
    end
    check({tag, "_accepts"}, n_acc, NS);
    @(negedge clk);
    upd_ready = 1'b0;
    check({tag, "_pass_done"}, pass_done, 1);
    @(negedge clk);
    check({tag, "_pass_done_pulse"}, pass_done, 0);
    for (int k = 0; k < n_acc; k++)
      check($sformatf("%s_order%0d", tag, k), got_idx[k], k);
  endtask

  task automatic wait_valid(input string tag);
    int cyc = 0;
    while (!upd_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_valid_seen"}, upd_valid, 1);
  endtask

  initial begin
    // Pass 1/2 expectations: x', y', sel' for each sprite (X_LIM=608, Y_LIM=448).
    tbl[0] = '{0,  10,  20,  2, -3,  2, 1,  12,  17,  3,  14,  14,  2};
    tbl[1] = '{1, 606,   1,  3, -2,  5, 0, 608,   0,  6, 605,   2,  5};
    tbl[2] = '{2, 100, 446, -8,  5, 31, 1,  93, 448,  0,  86, 443, 31};
    tbl[3] = '{3,   0, 448, -1,  1,  0, 0,   0, 448,  1,   1, 447,  0};

    rst = 1'b1; enable = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_x = '0; cfg_y = '0;
    cfg_dx = '0; cfg_dy = '0; cfg_sel = '0; cfg_vis = 1'b0; upd_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < NS; i++)
      cfg_write(tbl[i].idx, tbl[i].x, tbl[i].y, tbl[i].dx, tbl[i].dy, tbl[i].sel, tbl[i].vis);
    check("cfg_idle_busy", busy, 0);

    enable = 1'b1;
    run_pass(-1, 0, "p1");
    check("p1_first_latency", first_cyc, TP);
    for (int i = 0; i < NS; i++) begin
      check($sformatf("p1_s%0d_x", i), got_x[i], tbl[i].ex1);
      check($sformatf("p1_s%0d_y", i), got_y[i], tbl[i].ey1);
      check($sformatf("p1_s%0d_sel", i), got_sel[i], tbl[i].es1);
      check($sformatf("p1_s%0d_vis", i), got_vis[i], tbl[i].vis);
      $display("p1 sprite %0d: x=%0d y=%0d sel=%0d vis=%0d",
               i, got_x[i], got_y[i], got_sel[i], got_vis[i]);
    end
    run_pass(-1, 0, "p2");
    for (int i = 0; i < NS; i++) begin
      check($sformatf("p2_s%0d_x", i), got_x[i], tbl[i].ex2);
      check($sformatf("p2_s%0d_y", i), got_y[i], tbl[i].ey2);
      check($sformatf("p2_s%0d_sel", i), got_sel[i], tbl[i].es2);
      $display("p2 sprite %0d: x=%0d y=%0d sel=%0d", i, got_x[i], got_y[i], got_sel[i]);
    end

    // Backpressure on sprite 1 for 5 cycles.
    run_pass(1, 5, "p3");
    check("p3_s0_x", got_x[0], 16);
    check("p3_s1_xy", {got_x[1][9:0], got_y[1][8:0]}, {10'd602, 9'd4});
    check("p3_s1_sel", got_sel[1], 6);
    check("p3_no_overrun", tick_overrun, 0);
    $display("p3 sprite 1: x=%0d y=%0d sel=%0d", got_x[1], got_y[1], got_sel[1]);

    // Stall long enough for a tick to land while busy; a cfg write now must be dropped.
    upd_ready = 1'b0;
    wait_valid("p4");
    check("p4_busy", busy, 1);
    cfg_write(0, 300, 100, 1, 1, 9, 0);
    repeat (25) @(negedge clk);
    check("overrun_set", tick_overrun, 1);
    check("p4_held_rec", {upd_valid, upd_idx, upd_x}, {1'b1, 2'd0, 10'd18});
    run_pass(-1, 0, "p4");
    check("p4_s0_xy", {got_x[0][9:0], got_y[0][8:0]}, {10'd18, 9'd8});
    check("p4_s0_sel", got_sel[0], 2);
    run_pass(-1, 0, "p5");
    check("p5_s0_x", got_x[0], 20);
    check("p5_s0_y", got_y[0], 5);
    check("p5_s0_sel", got_sel[0], 3);
    check("overrun_sticky", tick_overrun, 1);
    $display("p5 sprite 0: x=%0d y=%0d sel=%0d", got_x[0], got_y[0], got_sel[0]);

    // Reset in the middle of a pass.
    upd_ready = 1'b0;
    wait_valid("p6");
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("midrst");
    rst = 1'b0;
    run_pass(-1, 0, "p7");
    check("p7_first_latency", first_cyc, TP);
    check("p7_s0_xy", {got_x[0][9:0], got_y[0][8:0]}, 0);
    check("p7_s2_sel", got_sel[2], 1);
    check("p7_s2_vis", got_vis[2], 0);
    check("p7_no_overrun", tick_overrun, 0);
    $display("p7 sprite 0: x=%0d y=%0d sel=%0d", got_x[0], got_y[0], got_sel[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
